// File: rtl/life_gen_engine.sv
// life_gen_engine: Game-of-Life (B3/S23) next-generation engine for a row-organised board RAM.
// The board is streamed one row per cycle through an above/cur/below window. All COLS cells of
// the current row are computed in parallel and written back in place.
// Optional feature: define LIFE_POPCOUNT_EN to add the pop_count output and its adder tree.
module life_gen_engine #(
    parameter int unsigned COLS   = 40,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ROW_AW = 5,
    parameter int unsigned WRAP   = 0,
    parameter int unsigned GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ROW_AW-1:0] rd_addr,
    input  logic [COLS-1:0]   rd_data,
    output logic              wr_en,
    output logic [ROW_AW-1:0] wr_addr,
    output logic [COLS-1:0]   wr_data,
    output logic [GEN_W-1:0]  gen_count,
    output logic              changed
`ifdef LIFE_POPCOUNT_EN
    ,
    output logic [ROW_AW+5:0] pop_count
`endif
);

    // Step timeline, counted from the cycle after the accepting edge (t = 0):
    //   t = 0 .. ROWS-1   issue read of row t (top neighbour row is issued on the accept edge)
    //   t = 1 .. ROWS+2   shift one incoming row into the window
    //   t = 4 .. ROWS+3   register the write of row t-4
    //   t = ROWS+4        finish: done pulse follows
    localparam int unsigned TW = $clog2(ROWS + 6);
    localparam logic [TW-1:0] T_RD_END    = TW'(ROWS);
    localparam logic [TW-1:0] T_SH_FIRST  = TW'(1);
    localparam logic [TW-1:0] T_ROW0      = TW'(2);
    localparam logic [TW-1:0] T_SH_LAST   = TW'(ROWS + 2);
    localparam logic [TW-1:0] T_WR_FIRST  = TW'(4);
    localparam logic [TW-1:0] T_WR_LAST   = TW'(ROWS + 3);
    localparam logic [TW-1:0] T_END       = TW'(ROWS + 4);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_CALC, S_DONE} state_t;

    state_t              state_q;
    logic [TW-1:0]       t_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_en_q;
    logic [ROW_AW-1:0]   rd_addr_q;
    logic                wr_en_q;
    logic [ROW_AW-1:0]   wr_addr_q;
    logic [COLS-1:0]     wr_data_q;
    logic [GEN_W-1:0]    gen_q;
    logic                changed_q;
    logic [COLS-1:0]     above_q;
    logic [COLS-1:0]     cur_q;
    logic [COLS-1:0]     below_q;
    logic [COLS-1:0]     row0_q;

    logic [COLS+1:0]     ext_a;
    logic [COLS+1:0]     ext_c;
    logic [COLS+1:0]     ext_b;
    logic [3:0]          nbr_cnt;
    logic [COLS-1:0]     wr_data_d;
    logic [COLS-1:0]     in_row_d;

`ifdef LIFE_POPCOUNT_EN
    localparam int unsigned PW = ROW_AW + 6;
    logic [PW-1:0]       pop_q;
    logic [PW-1:0]       pop_row_d;
`endif

    // Next generation of the current row; columns -1 and COLS are dead or wrapped
    always_comb begin
        ext_a     = {(WRAP != 0) ? above_q[0] : 1'b0, above_q, (WRAP != 0) ? above_q[COLS-1] : 1'b0};
        ext_c     = {(WRAP != 0) ? cur_q[0]   : 1'b0, cur_q,   (WRAP != 0) ? cur_q[COLS-1]   : 1'b0};
        ext_b     = {(WRAP != 0) ? below_q[0] : 1'b0, below_q, (WRAP != 0) ? below_q[COLS-1] : 1'b0};
        nbr_cnt   = '0;
        wr_data_d = '0;
        for (int unsigned b = 0; b < COLS; b++) begin
            nbr_cnt = {3'b000, ext_a[b+2]} + {3'b000, ext_a[b+1]} + {3'b000, ext_a[b]}
                    + {3'b000, ext_c[b+2]}                        + {3'b000, ext_c[b]}
                    + {3'b000, ext_b[b+2]} + {3'b000, ext_b[b+1]} + {3'b000, ext_b[b]};
            wr_data_d[b] = (nbr_cnt == 4'd3) || (cur_q[b] && (nbr_cnt == 4'd2));
        end
    end

    // Row entering the window: zero or RAM data for the top neighbour, RAM data for board rows,
    // and zero or the saved row-0 copy for the row below the last one
    always_comb begin
        if (t_q == T_SH_LAST) begin
            in_row_d = (WRAP != 0) ? row0_q : '0;
        end else if ((t_q == T_SH_FIRST) && (WRAP == 0)) begin
            in_row_d = '0;
        end else begin
            in_row_d = rd_data;
        end
    end

`ifdef LIFE_POPCOUNT_EN
    // Live-cell count of the row about to be written
    always_comb begin
        pop_row_d = '0;
        for (int unsigned b = 0; b < COLS; b++) begin
            pop_row_d = pop_row_d + PW'(wr_data_d[b]);
        end
    end
`endif

    // Step sequencer: FSM, read/write strobes, row window and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            t_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            gen_q     <= '0;
            changed_q <= 1'b0;
            above_q   <= '0;
            cur_q     <= '0;
            below_q   <= '0;
            row0_q    <= '0;
`ifdef LIFE_POPCOUNT_EN
            pop_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_PRIME;
                        t_q       <= '0;
                        busy_q    <= 1'b1;
                        changed_q <= 1'b0;
                        rd_en_q   <= (WRAP != 0);
                        rd_addr_q <= (WRAP != 0) ? ROW_AW'(ROWS - 1) : '0;
`ifdef LIFE_POPCOUNT_EN
                        pop_q     <= '0;
`endif
                    end
                end
                S_PRIME, S_CALC: begin
                    t_q <= t_q + 1'b1;

                    if (t_q < T_RD_END) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ROW_AW'(t_q);
                    end else begin
                        rd_en_q   <= 1'b0;
                    end

                    if ((t_q >= T_SH_FIRST) && (t_q <= T_SH_LAST)) begin
                        above_q <= cur_q;
                        cur_q   <= below_q;
                        below_q <= in_row_d;
                    end

                    if (t_q == T_ROW0) begin
                        row0_q <= rd_data;
                    end

                    if ((t_q >= T_WR_FIRST) && (t_q <= T_WR_LAST)) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ROW_AW'(t_q - T_WR_FIRST);
                        wr_data_q <= wr_data_d;
                        changed_q <= changed_q | (wr_data_d != cur_q);
`ifdef LIFE_POPCOUNT_EN
                        pop_q     <= pop_q + pop_row_d;
`endif
                    end else begin
                        wr_en_q   <= 1'b0;
                    end

                    if (t_q == T_ROW0) begin
                        state_q <= S_CALC;
                    end

                    if (t_q == T_END) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        gen_q   <= gen_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign gen_count = gen_q;
    assign changed   = changed_q;
`ifdef LIFE_POPCOUNT_EN
    assign pop_count = pop_q;
`endif

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench for life_gen_engine: one dead-edge instance and one toroidal instance,
// each with its own board RAM (one-cycle read latency). pop_count checks follow LIFE_POPCOUNT_EN.
module tb_life_gen_engine;

    localparam int unsigned COLS   = 40;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned ROW_AW = 5;
    localparam int unsigned GEN_W  = 16;
    localparam int unsigned LAT    = ROWS + 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset0, reset1, start0, start1;
    logic              busy0, done0, rd_en0, wr_en0, changed0;
    logic              busy1, done1, rd_en1, wr_en1, changed1;
    logic [ROW_AW-1:0] rd_addr0, wr_addr0, rd_addr1, wr_addr1;
    logic [COLS-1:0]   rd_data0, wr_data0, rd_data1, wr_data1;
    logic [GEN_W-1:0]  gen0, gen1;
`ifdef LIFE_POPCOUNT_EN
    logic [ROW_AW+5:0] pop0, pop1;
`endif

    logic [COLS-1:0]   mem0 [ROWS];
    logic [COLS-1:0]   mem1 [ROWS];
    logic              ld_en0, ld_en1;
    logic [ROW_AW-1:0] ld_addr;
    logic [COLS-1:0]   ld_data;
    logic [COLS-1:0]   img [ROWS];

    int          checks   = 0;
    int          failures = 0;
    int unsigned bad_rd   = 0;
    int unsigned bad_wa   = 0;
    int unsigned bad_ov   = 0;
    int unsigned wr_cnt0  = 0;
    logic [ROW_AW-1:0] wa_next0 = '0;

    life_gen_engine #(.COLS(COLS), .ROWS(ROWS), .ROW_AW(ROW_AW), .WRAP(0), .GEN_W(GEN_W)) u_dut0 (
        .clk(clk), .reset(reset0), .start(start0), .busy(busy0), .done(done0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .gen_count(gen0), .changed(changed0)
`ifdef LIFE_POPCOUNT_EN
        , .pop_count(pop0)
`endif
    );

    life_gen_engine #(.COLS(COLS), .ROWS(ROWS), .ROW_AW(ROW_AW), .WRAP(1), .GEN_W(GEN_W)) u_dut1 (
        .clk(clk), .reset(reset1), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .gen_count(gen1), .changed(changed1)
`ifdef LIFE_POPCOUNT_EN
        , .pop_count(pop1)
`endif
    );

    // Board RAM for the dead-edge instance
    always @(posedge clk) begin
        if (ld_en0) mem0[ld_addr] <= ld_data;
        else if (wr_en0) mem0[wr_addr0] <= wr_data0;
        if (rd_en0) rd_data0 <= mem0[rd_addr0];
    end

    // Board RAM for the toroidal instance
    always @(posedge clk) begin
        if (ld_en1) mem1[ld_addr] <= ld_data;
        else if (wr_en1) mem1[wr_addr1] <= wr_data1;
        if (rd_en1) rd_data1 <= mem1[rd_addr1];
    end

    // Bus monitor: read range, write row order, writes overlapping done
    always @(negedge clk) begin
        if (reset0) begin
            wa_next0 <= '0;
        end else if (wr_en0) begin
            if (wr_addr0 != wa_next0) bad_wa <= bad_wa + 1;
            wa_next0 <= (32'(wr_addr0) == ROWS - 1) ? '0 : wr_addr0 + 1'b1;
            wr_cnt0  <= wr_cnt0 + 1;
        end
        bad_rd <= bad_rd + ((rd_en0 && 32'(rd_addr0) >= ROWS) ? 1 : 0)
                         + ((rd_en1 && 32'(rd_addr1) >= ROWS) ? 1 : 0);
        bad_ov <= bad_ov + ((wr_en0 && done0) ? 1 : 0) + ((wr_en1 && done1) ? 1 : 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [COLS-1:0] col_bit(input int unsigned c);
        logic [COLS-1:0] w;
        w = '0;
        w[COLS-1-c] = 1'b1;
        return w;
    endfunction

    task automatic clear_img();
        for (int r = 0; r < ROWS; r++) img[r] = '0;
    endtask

    task automatic load(input int unsigned g);
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            ld_en0  = (g == 0);
            ld_en1  = (g == 1);
            ld_addr = ROW_AW'(r);
            ld_data = img[r];
        end
        @(negedge clk);
        ld_en0 = 1'b0;
        ld_en1 = 1'b0;
    endtask

    task automatic check_board(input int unsigned g, input string tag);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("%s_row%0d", tag, r), (g == 0) ? mem0[r] : mem1[r], img[r]);
        end
    endtask

    task automatic run_step(input int unsigned g, output int unsigned lat);
        @(negedge clk);
        if (g == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        lat = 0;
        while ((((g == 0) ? done0 : done1) == 1'b0) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic step_chk(input int unsigned g, input string tag, input logic exp_chg,
                            input int unsigned exp_gen, input int unsigned exp_pop);
        int unsigned lat;
        run_step(g, lat);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_changed"}, (g == 0) ? changed0 : changed1, exp_chg);
        check({tag, "_gen"}, (g == 0) ? gen0 : gen1, exp_gen);
`ifdef LIFE_POPCOUNT_EN
        check({tag, "_pop"}, (g == 0) ? pop0 : pop1, exp_pop);
`else
        if (exp_pop > COLS * ROWS) $display("note: %s population out of range", tag);
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, (g == 0) ? done0 : done1, 1'b0);
        check({tag, "_changed_held"}, (g == 0) ? changed0 : changed1, exp_chg);
    endtask

    initial begin
        int unsigned lat;
        int unsigned eg0;
        int unsigned wc;
        logic found;

        reset0 = 1'b1; reset1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        ld_en0 = 1'b0; ld_en1 = 1'b0;
        ld_addr = '0;  ld_data = '0;
        repeat (3) @(negedge clk);

        check("rst_ctrl", {busy0, done0, rd_en0, wr_en0, changed0}, 5'b0);
        check("rst_gen", gen0, 0);
        check("rst_addr", {rd_addr0, wr_addr0}, 0);
        check("rst_wdata", wr_data0, 0);
`ifdef LIFE_POPCOUNT_EN
        check("rst_pop", pop0, 0);
`endif
        reset0 = 1'b0; reset1 = 1'b0;
        eg0 = 0;

        // Reset in the middle of the write burst, then a clean step
        clear_img();
        img[12] = col_bit(19) | col_bit(20) | col_bit(21);
        load(0);
        load(1);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (wr_en0 && wr_addr0 == ROW_AW'(10)) found = 1'b1;
            else @(negedge clk);
        end
        check("t1_reach_row10", found, 1'b1);
        reset0 = 1'b1;
        #1;
        check("t1_wr_drop", wr_en0, 1'b0);
        check("t1_busy", busy0, 1'b0);
        check("t1_gen", gen0, eg0);
        @(negedge clk); reset0 = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_idle", {busy0, wr_en0, done0}, 3'b0);
        check_board(0, "t1_after_reset");
        eg0++;
        step_chk(0, "t1_clean", 1'b1, eg0, 3);
        clear_img();
        img[11] = col_bit(20); img[12] = col_bit(20); img[13] = col_bit(20);
        check_board(0, "t1_board");

        // Horizontal blinker, two steps
        clear_img();
        img[12] = col_bit(19) | col_bit(20) | col_bit(21);
        load(0);
        eg0++;
        step_chk(0, "t3_s1", 1'b1, eg0, 3);
        clear_img();
        img[11] = col_bit(20); img[12] = col_bit(20); img[13] = col_bit(20);
        check_board(0, "t3_s1_board");
        eg0++;
        step_chk(0, "t3_s2", 1'b1, eg0, 3);
        clear_img();
        img[12] = col_bit(19) | col_bit(20) | col_bit(21);
        check_board(0, "t3_s2_board");

        // Block still life
        clear_img();
        img[5] = col_bit(10) | col_bit(11);
        img[6] = col_bit(10) | col_bit(11);
        load(0);
        eg0++;
        step_chk(0, "t2", 1'b0, eg0, 4);
        check_board(0, "t2_board");

        // Glider in the top-left corner, four steps
        clear_img();
        img[0] = col_bit(1);
        img[1] = col_bit(2);
        img[2] = col_bit(0) | col_bit(1) | col_bit(2);
        load(0);
        for (int s = 1; s <= 4; s++) begin
            eg0++;
            step_chk(0, $sformatf("t4_s%0d", s), 1'b1, eg0, 5);
        end
        clear_img();
        img[1] = col_bit(2);
        img[2] = col_bit(3);
        img[3] = col_bit(1) | col_bit(2) | col_bit(3);
        check_board(0, "t4_board");

        // Vertical blinker on column 0: dead edges versus toroidal wrap
        clear_img();
        img[0] = col_bit(0); img[1] = col_bit(0); img[2] = col_bit(0);
        load(0);
        load(1);
        eg0++;
        step_chk(0, "t5_dead", 1'b1, eg0, 2);
        step_chk(1, "t5_wrap", 1'b1, 1, 3);
        clear_img();
        img[1] = col_bit(0) | col_bit(1);
        check_board(0, "t5_dead_board");
        img[1] = col_bit(COLS-1) | col_bit(0) | col_bit(1);
        check_board(1, "t5_wrap_board");

        // start held high for the whole step
        clear_img();
        img[5] = col_bit(10) | col_bit(11);
        img[6] = col_bit(10) | col_bit(11);
        load(0);
        wc = wr_cnt0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0;
        eg0++;
        check("t6_hold_latency", lat, LAT);
        repeat (6) @(negedge clk);
        check("t6_hold_writes", wr_cnt0 - wc, ROWS);
        check("t6_hold_gen", gen0, eg0);
        check("t6_hold_idle", busy0, 1'b0);

        // start pulsed in the middle of the write burst
        wc = wr_cnt0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        lat = 0;
        while (!done0 && lat < 200) begin
            start0 = (lat == 15);
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0;
        eg0++;
        check("t6_pulse_latency", lat, LAT);
        repeat (6) @(negedge clk);
        check("t6_pulse_writes", wr_cnt0 - wc, ROWS);
        check("t6_pulse_gen", gen0, eg0);
        check("t6_pulse_idle", busy0, 1'b0);
        check_board(0, "t6_board");

        check("rd_range", bad_rd, 0);
        check("wr_sequence", bad_wa, 0);
        check("wr_done_overlap", bad_ov, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
